// File: rtl/reorder_buffer_pkg.sv
// Shared widths, types and helpers for the reorder buffer and its bus interface.
package reorder_buffer_pkg;

    localparam int ROB_ADDR_WIDTH = 4;
    localparam int ROB_DEPTH      = 1 << ROB_ADDR_WIDTH;
    localparam int ROB_PTR_WIDTH  = ROB_ADDR_WIDTH + 1;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 32;

    typedef logic [ROB_ADDR_WIDTH-1:0] rob_id_t;
    typedef logic [ROB_PTR_WIDTH-1:0]  rob_ptr_t;
    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;

    // What the head entry does on the coming edge.
    typedef enum logic [1:0] {
        RETIRE_NONE,
        RETIRE_COMMIT,
        RETIRE_FLUSH
    } retire_op_t;

    // Pointers carry one extra wrap bit: same index with different wrap means full.
    function automatic logic ptr_full(rob_ptr_t head, rob_ptr_t tail);
        return (head[ROB_ADDR_WIDTH-1:0] == tail[ROB_ADDR_WIDTH-1:0]) &&
               (head[ROB_ADDR_WIDTH] != tail[ROB_ADDR_WIDTH]);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / write-back / operand-read / regfile rename+commit signals of the reorder buffer.
// master: surrounding pipeline and regfile; slave: the reorder buffer itself.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic      alloc_en;
    logic      alloc_has_dest;
    reg_addr_t alloc_reg_addr;
    logic      alloc_ready;
    rob_id_t   alloc_id;

    logic      rf_write_en;
    reg_addr_t rf_write_addr;
    rob_id_t   rf_write_ref_id;

    logic      wb_en;
    rob_id_t   wb_id;
    data_t     wb_data;
    logic      wb_exception;

    rob_id_t   read_id_1;
    rob_id_t   read_id_2;
    logic      read_done_1;
    logic      read_done_2;
    data_t     read_data_1;
    data_t     read_data_2;

    logic      commit_en;
    logic      commit_restore;
    reg_addr_t commit_addr;
    data_t     commit_data;
    logic      empty;

    modport master (
        output alloc_en, alloc_has_dest, alloc_reg_addr,
        input  alloc_ready, alloc_id,
        input  rf_write_en, rf_write_addr, rf_write_ref_id,
        output wb_en, wb_id, wb_data, wb_exception,
        output read_id_1, read_id_2,
        input  read_done_1, read_done_2, read_data_1, read_data_2,
        input  commit_en, commit_restore, commit_addr, commit_data, empty
    );

    modport slave (
        input  alloc_en, alloc_has_dest, alloc_reg_addr,
        output alloc_ready, alloc_id,
        output rf_write_en, rf_write_addr, rf_write_ref_id,
        input  wb_en, wb_id, wb_data, wb_exception,
        input  read_id_1, read_id_2,
        output read_done_1, read_done_2, read_data_1, read_data_2,
        output commit_en, commit_restore, commit_addr, commit_data, empty
    );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at dispatch, renames in the regfile,
// collects write-backs and retires strictly in order onto the regfile commit port.
// An excepting head entry flushes the whole buffer with a one-cycle commit_restore.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave rob_bus
);

    rob_ptr_t  head_q;
    rob_ptr_t  tail_q;
    rob_id_t   head_idx;
    rob_id_t   tail_idx;

    logic [ROB_DEPTH-1:0] valid_q;
    logic [ROB_DEPTH-1:0] done_q;
    logic [ROB_DEPTH-1:0] exc_q;
    logic [ROB_DEPTH-1:0] has_dest_q;
    reg_addr_t reg_addr_q [ROB_DEPTH];
    data_t     data_q     [ROB_DEPTH];

    logic      commit_en_q;
    logic      commit_restore_q;
    reg_addr_t commit_addr_q;
    data_t     commit_data_q;

    logic       full;
    logic       grant;
    logic       wb_hit;
    retire_op_t retire_op;

    assign head_idx = head_q[ROB_ADDR_WIDTH-1:0];
    assign tail_idx = tail_q[ROB_ADDR_WIDTH-1:0];
    assign full     = ptr_full(head_q, tail_q);

    assign rob_bus.alloc_ready     = !full && !commit_restore_q;
    assign rob_bus.alloc_id        = tail_idx;
    assign grant                   = rob_bus.alloc_en && rob_bus.alloc_ready;
    assign rob_bus.rf_write_en     = grant && rob_bus.alloc_has_dest;
    assign rob_bus.rf_write_addr   = rob_bus.alloc_reg_addr;
    assign rob_bus.rf_write_ref_id = tail_idx;

    assign wb_hit = rob_bus.wb_en && valid_q[rob_bus.wb_id];

    assign rob_bus.empty          = (head_q == tail_q);
    assign rob_bus.commit_en      = commit_en_q;
    assign rob_bus.commit_restore = commit_restore_q;
    assign rob_bus.commit_addr    = commit_addr_q;
    assign rob_bus.commit_data    = commit_data_q;

    // Retire decision from the head state as it stands before the edge.
    always_comb begin
        retire_op = RETIRE_NONE;
        if (valid_q[head_idx] && done_q[head_idx]) begin
            retire_op = exc_q[head_idx] ? RETIRE_FLUSH : RETIRE_COMMIT;
        end
    end

    // Operand lookup with same-cycle write-back bypass.
    always_comb begin
        rob_bus.read_done_1 = valid_q[rob_bus.read_id_1] & done_q[rob_bus.read_id_1];
        rob_bus.read_data_1 = data_q[rob_bus.read_id_1];
        rob_bus.read_done_2 = valid_q[rob_bus.read_id_2] & done_q[rob_bus.read_id_2];
        rob_bus.read_data_2 = data_q[rob_bus.read_id_2];
        if (rob_bus.wb_en && rob_bus.wb_id == rob_bus.read_id_1 && valid_q[rob_bus.read_id_1]) begin
            rob_bus.read_done_1 = 1'b1;
            rob_bus.read_data_1 = rob_bus.wb_data;
        end
        if (rob_bus.wb_en && rob_bus.wb_id == rob_bus.read_id_2 && valid_q[rob_bus.read_id_2]) begin
            rob_bus.read_done_2 = 1'b1;
            rob_bus.read_data_2 = rob_bus.wb_data;
        end
    end

    // Head/tail pointers; a flush returns both to zero and drops any same-cycle allocation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (retire_op == RETIRE_FLUSH) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (grant) begin
                tail_q <= tail_q + rob_ptr_t'(1);
            end
            if (retire_op == RETIRE_COMMIT) begin
                head_q <= head_q + rob_ptr_t'(1);
            end
        end
    end

    // Per-entry status flags: allocate, write-back and retire may all land on one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            done_q     <= '0;
            exc_q      <= '0;
            has_dest_q <= '0;
        end else if (retire_op == RETIRE_FLUSH) begin
            valid_q <= '0;
            done_q  <= '0;
            exc_q   <= '0;
        end else begin
            if (grant) begin
                valid_q[tail_idx]    <= 1'b1;
                done_q[tail_idx]     <= 1'b0;
                exc_q[tail_idx]      <= 1'b0;
                has_dest_q[tail_idx] <= rob_bus.alloc_has_dest;
            end
            if (wb_hit) begin
                done_q[rob_bus.wb_id] <= 1'b1;
                exc_q[rob_bus.wb_id]  <= rob_bus.wb_exception;
            end
            if (retire_op == RETIRE_COMMIT) begin
                valid_q[head_idx] <= 1'b0;
            end
        end
    end

    // Entry payload; only meaningful while the matching flags say so, so no reset needed.
    always_ff @(posedge clk) begin
        if (grant) begin
            reg_addr_q[tail_idx] <= rob_bus.alloc_reg_addr;
        end
        if (wb_hit) begin
            data_q[rob_bus.wb_id] <= rob_bus.wb_data;
        end
    end

    // Registered commit port; addr/data hold their last retired value between commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_en_q      <= 1'b0;
            commit_restore_q <= 1'b0;
            commit_addr_q    <= '0;
            commit_data_q    <= '0;
        end else begin
            commit_en_q      <= (retire_op == RETIRE_COMMIT) && has_dest_q[head_idx];
            commit_restore_q <= (retire_op == RETIRE_FLUSH);
            if (retire_op == RETIRE_COMMIT) begin
                commit_addr_q <= reg_addr_q[head_idx];
                commit_data_q <= data_q[head_idx];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer with a commit scoreboard checked by a negedge monitor.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk;
    logic rst;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk     (clk),
        .rst     (rst),
        .rob_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        restore;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_commit(input logic [4:0] addr, input logic [31:0] data);
        exp_t e;
        e.restore = 1'b0;
        e.addr    = addr;
        e.data    = data;
        exp_q.push_back(e);
    endtask

    task automatic push_restore();
        exp_t e;
        e.restore = 1'b1;
        e.addr    = '0;
        e.data    = '0;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_inputs();
        bus.alloc_en       = 1'b0;
        bus.alloc_has_dest = 1'b0;
        bus.alloc_reg_addr = '0;
        bus.wb_en          = 1'b0;
        bus.wb_id          = '0;
        bus.wb_data        = '0;
        bus.wb_exception   = 1'b0;
        bus.read_id_1      = '0;
        bus.read_id_2      = '0;
    endtask

    task automatic drive_alloc(input logic has_dest, input logic [4:0] addr);
        bus.alloc_en       = 1'b1;
        bus.alloc_has_dest = has_dest;
        bus.alloc_reg_addr = addr;
    endtask

    task automatic drive_wb(input logic [3:0] id, input logic [31:0] data, input logic exc);
        bus.wb_en        = 1'b1;
        bus.wb_id        = id;
        bus.wb_data      = data;
        bus.wb_exception = exc;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 1'b0;
        #2;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("rst_commit_en", 32'(bus.commit_en), 32'd0);
        chk("rst_commit_restore", 32'(bus.commit_restore), 32'd0);
        chk("rst_commit_addr", 32'(bus.commit_addr), 32'd0);
        chk("rst_commit_data", bus.commit_data, 32'd0);
        step();
        rst = 1'b1;
    endtask

    // Scoreboard monitor: every visible commit/restore must match the next expectation.
    always @(negedge clk) begin
        if (rst && (bus.commit_en || bus.commit_restore)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_commit en=%0b restore=%0b addr=%0d data=%h",
                         bus.commit_en, bus.commit_restore, bus.commit_addr, bus.commit_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.restore) begin
                    if (!(bus.commit_restore === 1'b1 && bus.commit_en === 1'b0)) begin
                        failures++;
                        $display("FAIL restore_pulse actual en=%0b restore=%0b required en=0 restore=1",
                                 bus.commit_en, bus.commit_restore);
                    end
                end else if (!(bus.commit_en === 1'b1 && bus.commit_restore === 1'b0 &&
                               bus.commit_addr === e.addr && bus.commit_data === e.data)) begin
                    failures++;
                    $display("FAIL commit actual en=%0b restore=%0b addr=%0d data=%h required en=1 restore=0 addr=%0d data=%h",
                             bus.commit_en, bus.commit_restore, bus.commit_addr, bus.commit_data,
                             e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        do_reset();

        // Idle after reset
        step();
        chk("idle_empty", 32'(bus.empty), 32'd1);
        chk("idle_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("idle_commit_en", 32'(bus.commit_en), 32'd0);
        chk("idle_commit_restore", 32'(bus.commit_restore), 32'd0);

        // Single alloc, write-back, commit
        drive_alloc(1'b1, 5'd1);
        #1;
        chk("t1_rf_write_en", 32'(bus.rf_write_en), 32'd1);
        chk("t1_rf_write_addr", 32'(bus.rf_write_addr), 32'd1);
        chk("t1_rf_write_ref_id", 32'(bus.rf_write_ref_id), 32'd0);
        chk("t1_alloc_id", 32'(bus.alloc_id), 32'd0);
        push_commit(5'd1, 32'h12345678);
        step();
        bus.alloc_en = 1'b0;
        #1;
        chk("t1_not_empty", 32'(bus.empty), 32'd0);
        drive_wb(4'd0, 32'h12345678, 1'b0);
        step();
        bus.wb_en = 1'b0;
        idle(3);
        chk("t1_empty_after", 32'(bus.empty), 32'd1);

        // Out-of-order write-back, in-order commit
        do_reset();
        drive_alloc(1'b1, 5'd3);
        push_commit(5'd3, 32'h00000011);
        step();
        drive_alloc(1'b1, 5'd4);
        #1;
        chk("t2_alloc_id", 32'(bus.alloc_id), 32'd1);
        push_commit(5'd4, 32'habcdef00);
        step();
        bus.alloc_en = 1'b0;
        drive_wb(4'd1, 32'habcdef00, 1'b0);
        step();
        drive_wb(4'd0, 32'h00000011, 1'b0);
        step();
        bus.wb_en = 1'b0;
        idle(4);
        chk("t2_empty_after", 32'(bus.empty), 32'd1);

        // Fill to full, blocked alloc, retire, wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_alloc(1'b1, 5'(i + 1));
            #1;
            chk("t3_fill_alloc_id", 32'(bus.alloc_id), 32'(i));
            step();
        end
        drive_alloc(1'b1, 5'd20);
        #1;
        chk("t3_full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
        chk("t3_full_rf_write_en", 32'(bus.rf_write_en), 32'd0);
        step();
        bus.alloc_en = 1'b0;
        drive_wb(4'd0, 32'h000000a0, 1'b0);
        push_commit(5'd1, 32'h000000a0);
        step();
        bus.wb_en = 1'b0;
        drive_alloc(1'b1, 5'd9);
        #1;
        chk("t3_retire_cycle_alloc_ready", 32'(bus.alloc_ready), 32'd0);
        chk("t3_retire_cycle_rf_write_en", 32'(bus.rf_write_en), 32'd0);
        step();
        chk("t3_wrap_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("t3_wrap_alloc_id", 32'(bus.alloc_id), 32'd0);
        chk("t3_wrap_rf_write_en", 32'(bus.rf_write_en), 32'd1);
        chk("t3_wrap_ref_id", 32'(bus.rf_write_ref_id), 32'd0);
        step();
        bus.alloc_en = 1'b0;
        #1;
        chk("t3_wrapped_full", 32'(bus.alloc_ready), 32'd0);
        idle(2);

        // Exception at head flushes everything
        do_reset();
        drive_alloc(1'b1, 5'd5);
        step();
        drive_alloc(1'b1, 5'd6);
        step();
        drive_alloc(1'b1, 5'd7);
        step();
        bus.alloc_en = 1'b0;
        drive_wb(4'd0, 32'hdeadbeef, 1'b1);
        push_restore();
        step();
        bus.wb_en = 1'b0;
        drive_alloc(1'b1, 5'd8);
        #1;
        chk("t4_discarded_grant", 32'(bus.rf_write_en), 32'd1);
        chk("t4_discarded_id", 32'(bus.alloc_id), 32'd3);
        step();
        bus.alloc_en = 1'b0;
        drive_wb(4'd1, 32'h00000055, 1'b0);
        bus.read_id_1 = 4'd1;
        #1;
        chk("t4_restore_alloc_ready", 32'(bus.alloc_ready), 32'd0);
        chk("t4_restore_empty", 32'(bus.empty), 32'd1);
        chk("t4_late_wb_no_bypass", 32'(bus.read_done_1), 32'd0);
        step();
        bus.wb_en = 1'b0;
        #1;
        chk("t4_after_alloc_ready", 32'(bus.alloc_ready), 32'd1);
        chk("t4_after_alloc_id", 32'(bus.alloc_id), 32'd0);
        chk("t4_late_wb_ignored", 32'(bus.read_done_1), 32'd0);
        drive_alloc(1'b1, 5'd10);
        push_commit(5'd10, 32'h00000077);
        step();
        bus.alloc_en = 1'b0;
        drive_wb(4'd0, 32'h00000077, 1'b0);
        step();
        bus.wb_en = 1'b0;
        idle(4);
        chk("t4_empty_after", 32'(bus.empty), 32'd1);

        // Operand bypass and retire of an entry without destination
        do_reset();
        drive_alloc(1'b1, 5'd11);
        push_commit(5'd11, 32'h000000d0);
        step();
        drive_alloc(1'b1, 5'd12);
        push_commit(5'd12, 32'h000000d1);
        step();
        drive_alloc(1'b1, 5'd13);
        push_commit(5'd13, 32'h000000d2);
        step();
        drive_alloc(1'b0, 5'd14);
        #1;
        chk("t5_nodest_rf_write_en", 32'(bus.rf_write_en), 32'd0);
        step();
        bus.alloc_en = 1'b0;
        drive_wb(4'd0, 32'h000000d0, 1'b0);
        step();
        drive_wb(4'd1, 32'h000000d1, 1'b0);
        step();
        drive_wb(4'd2, 32'h000000d2, 1'b0);
        bus.read_id_1 = 4'd3;
        #1;
        chk("t5_pending_not_done", 32'(bus.read_done_1), 32'd0);
        step();
        drive_wb(4'd3, 32'h00000033, 1'b0);
        bus.read_id_1 = 4'd3;
        bus.read_id_2 = 4'd2;
        #1;
        chk("t5_bypass_done", 32'(bus.read_done_1), 32'd1);
        chk("t5_bypass_data", bus.read_data_1, 32'h00000033);
        chk("t5_stored_done", 32'(bus.read_done_2), 32'd1);
        chk("t5_stored_data", bus.read_data_2, 32'h000000d2);
        step();
        bus.wb_en = 1'b0;
        idle(5);
        chk("t5_empty_after", 32'(bus.empty), 32'd1);

        idle(2);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
